// File: rtl/pwm_clk_div_var.sv
// Variable-divisor PWM prescaler: divides clk_i by any N with near-50% duty and a period tick.
// Optional feature macro: PWM_CLK_DIV_SYNC_EN adds i_sync to force a period restart in RUN.
module pwm_clk_div_var #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_divisor,
`ifdef PWM_CLK_DIV_SYNC_EN
    input  logic             i_sync,
`endif
    output logic             o_clk,
    output logic             o_tick,
    output logic [WIDTH-1:0] o_active_div
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BYPASS = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

    state_t           r_state;
    state_t           w_load_state;
    logic [WIDTH-1:0] r_ct;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] w_ct_inc;
    logic             r_clk;
    logic             r_tick;
    logic             w_load_clk;
    logic             w_load_tick;
    logic             w_wrap;
    logic             w_restart;

    // High-phase length ceil(n/2), written so it cannot overflow at n = 2^WIDTH-1.
    function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] n);
        return n - (n >> 1);
    endfunction

    assign w_ct_inc = r_ct + ONE;
    assign w_wrap   = (r_ct == (r_div - ONE));

`ifdef PWM_CLK_DIV_SYNC_EN
    assign w_restart = w_wrap | i_sync;
`else
    assign w_restart = w_wrap;
`endif

    // Decode of a freshly loaded divisor, shared by IDLE, BYPASS and the period boundary.
    always_comb begin
        w_load_state = ST_IDLE;
        w_load_clk   = 1'b0;
        w_load_tick  = 1'b0;
        if (i_divisor >= TWO) begin
            w_load_state = ST_RUN;
            w_load_clk   = 1'b1;
            w_load_tick  = 1'b1;
        end else if (i_divisor == ONE) begin
            w_load_state = ST_BYPASS;
            w_load_clk   = 1'b0;
            w_load_tick  = 1'b1;
        end else begin
            w_load_state = ST_IDLE;
            w_load_clk   = 1'b0;
            w_load_tick  = 1'b0;
        end
    end

    // Divider state machine; divisor only changes at a period boundary, so no runt pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ct    <= ZERO;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
            r_div   <= ZERO;
        end else if (!i_en) begin
            r_state <= ST_IDLE;
            r_ct    <= ZERO;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_BYPASS: begin
                    r_state <= w_load_state;
                    r_ct    <= ZERO;
                    r_clk   <= w_load_clk;
                    r_tick  <= w_load_tick;
                    r_div   <= i_divisor;
                end
                ST_RUN: begin
                    if (w_restart) begin
                        r_state <= w_load_state;
                        r_ct    <= ZERO;
                        r_clk   <= w_load_clk;
                        r_tick  <= w_load_tick;
                        r_div   <= i_divisor;
                    end else begin
                        r_ct    <= w_ct_inc;
                        r_clk   <= (w_ct_inc < high_len(r_div));
                        r_tick  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ct    <= ZERO;
                    r_clk   <= 1'b0;
                    r_tick  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clk        = (r_state == ST_BYPASS) ? clk_i : r_clk;
    assign o_tick       = r_tick;
    assign o_active_div = r_div;

endmodule

// File: tb/tb_pwm_clk_div_var.sv
// Randomized self-checking bench for pwm_clk_div_var against a period-level reference model.
module tb_pwm_clk_div_var;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] div;
    logic        sync;
    logic        o_clk;
    logic        o_tick;
    logic [15:0] act_div;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: mode 0=off, 1=dividing, 2=bypass; pos = cycle index inside the period.
    int m_mode = 0;
    int m_n    = 0;
    int m_pos  = 0;
    int m_tick = 0;

    pwm_clk_div_var #(.WIDTH(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .i_en        (en),
        .i_divisor   (div),
`ifdef PWM_CLK_DIV_SYNC_EN
        .i_sync      (sync),
`endif
        .o_clk       (o_clk),
        .o_tick      (o_tick),
        .o_active_div(act_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Start a new period with divisor d (used from off, bypass, or at the end of a period).
    task automatic model_start(input int d);
        m_n   = d;
        m_pos = 0;
        if (d >= 2) begin
            m_mode = 1; m_tick = 1;
        end else if (d == 1) begin
            m_mode = 2; m_tick = 1;
        end else begin
            m_mode = 0; m_tick = 0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_mode = 0; m_n = 0; m_pos = 0; m_tick = 0;
        end else if (!en) begin
            m_mode = 0; m_pos = 0; m_tick = 0;
        end else if (m_mode != 1 || m_pos == m_n - 1) begin
            model_start(int'(div));
        end else begin
            m_pos  = m_pos + 1;
            m_tick = 0;
        end
    endtask

    // One clock: advance model at the edge, check outputs just after it (and mid-low in bypass).
    task automatic step();
        int exp_clk;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (m_mode == 1)      exp_clk = (m_pos < (m_n + 1) / 2) ? 1 : 0;
        else if (m_mode == 2) exp_clk = 1;
        else                  exp_clk = 0;
        check_val("o_clk",        32'(o_clk),   32'(exp_clk));
        check_val("o_tick",       32'(o_tick),  32'(m_tick));
        check_val("o_active_div", 32'(act_div), 32'(m_n));
        if (m_mode == 2) begin
            @(negedge clk);
            #1;
            check_val("o_clk_bypass_low", 32'(o_clk), 32'd0);
        end
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        div   = 16'd0;
        sync  = 1'b0;
        run(2);
        check_val("reset_active_div", 32'(act_div), 32'd0);
        rst_n = 1'b1;

        // Even divisor, then odd divisor
        div = 16'd4; en = 1'b1; run(12);
        div = 16'd5; run(12);
        // Mid-period change is held off until the wrap
        div = 16'd4; run(6);
        div = 16'd6; run(14);
        // Bypass, then off via N=0 and via enable
        div = 16'd1; run(4);
        div = 16'd0; run(3);
        div = 16'd3; run(5);
        en = 1'b0; run(3);
        // Reset during the high phase of N=8
        en = 1'b1; div = 16'd8; run(3);
        rst_n = 1'b0; run(1);
        rst_n = 1'b1; run(10);
        // Maximum divisor: long high phase, no counter wrap
        div = 16'hFFFF; en = 1'b0; run(1);
        en = 1'b1; run(20);
        en = 1'b0; run(2);
        en = 1'b1; div = 16'd2; run(6);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0:       div = 16'd0;
                    1:       div = 16'd1;
                    default: div = 16'($urandom_range(2, 9));
                endcase
            end
            en    = ($urandom_range(0, 24) != 0);
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
